bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Round-robin arbiter for the shared system bus used by the bus masters (camera grabber, DMA engines, CPU bridge).
- Collects per-master requestBus lines and issues one-hot registered grants.
- Tracks each transaction from beginTransaction to endTransaction.
- A watchdog revokes stale grants and aborts hung transactions with a bus error and a forced endTransaction.

Parameters:
- NR_OF_MASTERS, 4, number of requesters (2..8).
- GRANT_TIMEOUT, 15, max cycles a granted master may take to assert beginTransaction before the grant is revoked.
- BUS_TIMEOUT, 1023, max cycles from beginTransaction to endTransaction before the transaction is aborted.

Ports:
- clock  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- busRequests  in  NR_OF_MASTERS  bit i = requestBus of master i.
- busGrants  out  NR_OF_MASTERS  registered one-hot grant; all zero when no master owns the bus.
- beginTransactionIn  in  1  OR of all masters' beginTransactionOut.
- endTransactionIn  in  1  OR of all endTransactionOut, including slaves.
- busErrorOut  out  1  one-cycle pulse, arbiter-detected timeout error.
- endTransactionOut  out  1  one-cycle forced end after an abort.
- activeMaster  out  clog2(NR_OF_MASTERS)  index of the current or last granted master.
- busIdle  out  1  high in IDLE only.

Behaviour:
- Reset (reset=0, asynchronous):
  - State is IDLE.
  - busGrants, busErrorOut, endTransactionOut and counters are 0; busIdle=1.
  - lastGrant = NR_OF_MASTERS-1, so master 0 has top priority after reset.
  - Reset mid-transaction drops the grant immediately and generates no error or end pulse.
- States: IDLE, GRANTED, BUSY, ABORT, FORCE_END, RELEASE.
- IDLE:
  - If any busRequests bit is set, pick the first set bit searching from (lastGrant+1) mod N upward with wrap.
  - Next cycle: busGrants = one-hot of winner, activeMaster = winner, lastGrant = winner, state GRANTED, counter cleared.
  - Grant latency: 1 cycle from request to grant.
  - No requests: stay in IDLE.
- GRANTED:
  - The grant is held regardless of busRequests; masters drop the request after grant.
  - beginTransactionIn=1 -> BUSY, counter cleared.
  - Otherwise the counter increments. When counter == GRANT_TIMEOUT -> RELEASE with no error. The pointer has already advanced, so the stalled master loses priority.
  - endTransactionIn in GRANTED is ignored.
- BUSY:
  - The grant is held.
  - endTransactionIn=1 -> RELEASE.
  - Else the counter increments. When counter == BUS_TIMEOUT -> ABORT.
  - If endTransactionIn and the timeout occur in the same cycle, the end wins: RELEASE, no error.
- ABORT: busErrorOut=1 for exactly one cycle, grant still held, then FORCE_END.
- FORCE_END: endTransactionOut=1 for exactly one cycle, grant still held, then RELEASE.
- RELEASE:
  - busGrants=0 for exactly one cycle (bus turnaround), then IDLE.
  - Back-to-back transactions therefore have a minimum gap of: 1 RELEASE + 1 IDLE cycle before the next grant.
- Arithmetic and encoding:
  - Counter width is clog2(max(GRANT_TIMEOUT, BUS_TIMEOUT)+1).
  - The counter saturates and never wraps.
  - Priority rotation is modulo NR_OF_MASTERS.
- Invariants:
  - busGrants is always one-hot or zero.
  - busErrorOut and endTransactionOut are never high in the same cycle.
  - busGrants never changes while in BUSY.

Test Plan:
- Reset, then raise busRequests=4'b0001 at cycle 0 -> busGrants=0001 at cycle 1. Pulse begin at cycle 3 and end at cycle 10 -> busGrants=0 at cycle 11 (RELEASE), busIdle=1 at cycle 12.
- Requests 4'b1111 held continuously, each master doing a 4-cycle transaction -> grant order 0,1,2,3,0,… with a 2-cycle gap between each grant drop and the next grant.
- Grant master 2 and never assert begin -> busGrants=0 after GRANT_TIMEOUT+1 cycles in GRANTED, no busErrorOut. A pending request from master 2 plus master 3 -> master 3 granted next.
- Begin then no end -> busErrorOut pulse after BUS_TIMEOUT cycles in BUSY, endTransactionOut pulse on the next cycle, then grant release. Also assert end exactly on the timeout cycle -> no error, normal RELEASE.
- Assert reset low asynchronously mid-BUSY -> busGrants=0 without waiting for a clock edge. After release, requests 4'b1000 and 4'b0001 together -> master 0 granted first.
- NR_OF_MASTERS=3, lastGrant=2, requests 3'b101 -> master 0 granted (wrap-around).

Source files
------------

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
//   Bundle of the arbitration and transaction-tracking signals shared between
//   the system-bus masters and the round-robin bus arbiter.
//
//   Signals
//     busRequests        bit i = requestBus of master i
//     busGrants          one-hot grant, zero when nobody owns the bus
//     beginTransactionIn OR of all masters' beginTransactionOut
//     endTransactionIn   OR of all endTransactionOut (masters and slaves)
//     busErrorOut        one-cycle arbiter timeout error pulse
//     endTransactionOut  one-cycle forced end after an abort
//     activeMaster       index of the current or last granted master
//     busIdle            high while the arbiter is idle
//
//   Modports
//     slave  : arbiter view (takes requests, drives grants and status)
//     master : bus-side view (drives requests and begin/end, sees grants)
// -----------------------------------------------------------------------------
interface bus_arbiter_if #(
  parameter int NR_OF_MASTERS = 4
) ();
  localparam int AW = (NR_OF_MASTERS > 1) ? $clog2(NR_OF_MASTERS) : 1;

  logic [NR_OF_MASTERS-1:0] busRequests;
  logic [NR_OF_MASTERS-1:0] busGrants;
  logic                     beginTransactionIn;
  logic                     endTransactionIn;
  logic                     busErrorOut;
  logic                     endTransactionOut;
  logic [AW-1:0]            activeMaster;
  logic                     busIdle;

  modport slave (
    input  busRequests,
    input  beginTransactionIn,
    input  endTransactionIn,
    output busGrants,
    output busErrorOut,
    output endTransactionOut,
    output activeMaster,
    output busIdle
  );

  modport master (
    output busRequests,
    output beginTransactionIn,
    output endTransactionIn,
    input  busGrants,
    input  busErrorOut,
    input  endTransactionOut,
    input  activeMaster,
    input  busIdle
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
//   Round-robin arbiter for the shared system bus. Issues registered one-hot
//   grants, follows each transaction from begin to end, and uses a watchdog
//   counter to revoke grants that are never used (no error) and to abort
//   transactions that never end (error pulse followed by a forced end).
//
//   Ports
//     clock  : system clock, all state changes on the rising edge
//     reset  : asynchronous, active-low reset
//     bus    : bus_arbiter_if.slave (requests, begin/end in; grants,
//              error, forced end, active master index and idle flag out)
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int NR_OF_MASTERS = 4,
  parameter int GRANT_TIMEOUT = 15,
  parameter int BUS_TIMEOUT   = 1023
) (
  input  logic          clock,
  input  logic          reset,
  bus_arbiter_if.slave  bus
);

  localparam int N      = NR_OF_MASTERS;
  localparam int AW     = $clog2(N);
  localparam int MAX_TO = (GRANT_TIMEOUT > BUS_TIMEOUT) ? GRANT_TIMEOUT : BUS_TIMEOUT;
  localparam int CW     = $clog2(MAX_TO + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GRANTED   = 3'd1,
    BUSY      = 3'd2,
    ABORT     = 3'd3,
    FORCE_END = 3'd4,
    RELEASE   = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   last_q, last_d;
  logic [N-1:0]    grant_q, grant_d;
  logic            err_q, err_d;
  logic            fend_q, fend_d;
  logic            idle_q, idle_d;

  logic [AW-1:0]   winner;
  logic [CW-1:0]   cnt_inc;

  // Saturating increment: the timeout compare normally stops the count first,
  // but the counter must never wrap regardless.
  assign cnt_inc = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Round-robin pick: first set request searching upward from the slot after
  // the last grant, wrapping modulo N.
  always_comb begin
    int  idx;
    logic found;
    winner = last_q;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_q) + k) % N;
      if (!found && bus.busRequests[idx[AW-1:0]]) begin
        winner = idx[AW-1:0];
        found  = 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= AW'(N - 1);
      grant_q <= '0;
      err_q   <= 1'b0;
      fend_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      fend_q  <= fend_d;
      idle_q  <= idle_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (|bus.busRequests) begin
          state_d = GRANTED;
          cnt_d   = '0;
          last_d  = winner;
        end
      end
      GRANTED: begin
        // endTransactionIn is deliberately ignored until the master begins.
        if (bus.beginTransactionIn) begin
          state_d = BUSY;
          cnt_d   = '0;
        end else if (cnt_q == CW'(GRANT_TIMEOUT)) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      BUSY: begin
        // A real end on the timeout cycle takes precedence over the abort.
        if (bus.endTransactionIn) begin
          state_d = RELEASE;
        end else if (cnt_q == CW'(BUS_TIMEOUT)) begin
          state_d = ABORT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ABORT:     state_d = FORCE_END;
      FORCE_END: state_d = RELEASE;
      RELEASE:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output logic: computes the next value of every registered output from the
  // next state, so all outputs come straight from flops.
  always_comb begin
    grant_d = '0;
    case (state_d)
      GRANTED, BUSY, ABORT, FORCE_END: grant_d = {{(N-1){1'b0}}, 1'b1} << last_d;
      default:                         grant_d = '0;
    endcase
    err_d  = (state_d == ABORT);
    fend_d = (state_d == FORCE_END);
    idle_d = (state_d == IDLE);
  end

  assign bus.busGrants         = grant_q;
  assign bus.busErrorOut       = err_q;
  assign bus.endTransactionOut = fend_q;
  assign bus.activeMaster      = last_q;
  assign bus.busIdle           = idle_q;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;

  localparam int GT = 6;
  localparam int BT = 20;

  logic clock;
  logic reset;

  bus_arbiter_if #(.NR_OF_MASTERS(4)) bif ();
  bus_arbiter_if #(.NR_OF_MASTERS(3)) bif3 ();

  bus_arbiter #(.NR_OF_MASTERS(4), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  bus_arbiter #(.NR_OF_MASTERS(3), .GRANT_TIMEOUT(GT), .BUS_TIMEOUT(BT)) dut3 (
    .clock (clock),
    .reset (reset),
    .bus   (bif3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] prev_grant;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Ticks until a grant appears; n returns the number of edges waited.
  task automatic wait_grant(output int n);
    n = 0;
    while (bif.busGrants == 4'b0 && n < 20) begin
      tick();
      n++;
    end
    check("grant_arrived", 32'(bif.busGrants != 4'b0), 32'd1);
  endtask

  // Begin now, BUSY for len cycles, end -> leaves the arbiter in RELEASE.
  task automatic do_txn(input int len);
    bif.beginTransactionIn = 1'b1;
    tick();
    bif.beginTransactionIn = 1'b0;
    repeat (len - 1) tick();
    bif.endTransactionIn = 1'b1;
    tick();
    bif.endTransactionIn = 1'b0;
    check("txn_release_grant", 32'(bif.busGrants), 32'd0);
  endtask

  // Scoreboard: every new grant on the 4-master arbiter is popped and compared.
  always @(negedge clock) begin
    if (!reset) begin
      prev_grant = 4'b0;
    end else begin
      if (bif.busGrants != 4'b0 && prev_grant == 4'b0) begin
        if (exp_q.size() == 0) check("unexpected_grant", 32'(bif.busGrants), 32'd0);
        else check("grant_order", 32'(bif.busGrants), 32'(exp_q.pop_front()));
      end
      check("grant_onehot0", 32'($onehot0(bif.busGrants)), 32'd1);
      check("err_end_exclusive", 32'(bif.busErrorOut & bif.endTransactionOut), 32'd0);
      prev_grant = bif.busGrants;
    end
  end

  int rr_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    int   n;
    logic err_any;

    reset = 1'b0;
    bif.busRequests = '0;  bif.beginTransactionIn = 1'b0;  bif.endTransactionIn = 1'b0;
    bif3.busRequests = '0; bif3.beginTransactionIn = 1'b0; bif3.endTransactionIn = 1'b0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    check("rst_grants", 32'(bif.busGrants), 32'd0);
    check("rst_err", 32'(bif.busErrorOut), 32'd0);
    check("rst_fend", 32'(bif.endTransactionOut), 32'd0);
    check("rst_idle", 32'(bif.busIdle), 32'd1);
    check("rst_idle3", 32'(bif3.busIdle), 32'd1);
    reset = 1'b1;
    tick();

    // Single transaction with cycle-exact timing
    bif.busRequests = 4'b0001; exp_q.push_back(4'b0001);          // cycle 0
    tick();                                                       // cycle 1
    check("t1_grant", 32'(bif.busGrants), 32'h1);
    check("t1_active", 32'(bif.activeMaster), 32'd0);
    check("t1_not_idle", 32'(bif.busIdle), 32'd0);
    bif.busRequests = 4'b0000;
    tick(); tick();                                               // cycle 3
    bif.beginTransactionIn = 1'b1;
    tick();                                                       // cycle 4
    bif.beginTransactionIn = 1'b0;
    check("t1_busy_grant", 32'(bif.busGrants), 32'h1);
    repeat (6) tick();                                            // cycle 10
    bif.endTransactionIn = 1'b1;
    tick();                                                       // cycle 11
    bif.endTransactionIn = 1'b0;
    check("t1_release_grant", 32'(bif.busGrants), 32'd0);
    check("t1_release_idle", 32'(bif.busIdle), 32'd0);
    check("t1_release_err", 32'(bif.busErrorOut), 32'd0);
    tick();                                                       // cycle 12
    check("t1_idle", 32'(bif.busIdle), 32'd1);

    // Round robin with all requests held; fresh reset so master 0 leads
    reset = 1'b0; #2; reset = 1'b1;
    tick();
    bif.busRequests = 4'b1111;
    for (int i = 0; i < 5; i++) exp_q.push_back(4'(1 << rr_order[i]));
    for (int i = 0; i < 5; i++) begin
      wait_grant(n);
      check("rr_gap", 32'(n), (i == 0) ? 32'd1 : 32'd2);
      check("rr_active", 32'(bif.activeMaster), 32'(rr_order[i]));
      if (i == 4) bif.busRequests = 4'b0000;
      do_txn(4);
      if (i == 4) bif.busRequests = 4'b0000;
    end
    tick();

    // Grant timeout: master 2 never begins; master 3 then wins over master 2
    bif.busRequests = 4'b0100; exp_q.push_back(4'b0100);
    wait_grant(n);
    check("gt_latency", 32'(n), 32'd1);
    check("gt_active", 32'(bif.activeMaster), 32'd2);
    bif.busRequests = 4'b1100; exp_q.push_back(4'b1000);
    err_any = 1'b0;
    for (int i = 0; i < GT; i++) begin
      tick();
      err_any = err_any | bif.busErrorOut;
    end
    check("gt_still_granted", 32'(bif.busGrants), 32'h4);
    tick();
    err_any = err_any | bif.busErrorOut;
    check("gt_revoked", 32'(bif.busGrants), 32'd0);
    check("gt_no_error", 32'(err_any), 32'd0);
    wait_grant(n);
    check("gt_next_gap", 32'(n), 32'd2);
    check("gt_next_active", 32'(bif.activeMaster), 32'd3);
    bif.busRequests = 4'b0000;
    do_txn(2);
    tick();

    // Bus timeout: begin without end -> error, forced end, release
    bif.busRequests = 4'b0001; exp_q.push_back(4'b0001);
    wait_grant(n);
    bif.busRequests = 4'b0000;
    bif.beginTransactionIn = 1'b1;
    tick();
    bif.beginTransactionIn = 1'b0;
    err_any = 1'b0;
    for (int i = 0; i < BT; i++) begin
      tick();
      err_any = err_any | bif.busErrorOut;
    end
    check("bt_no_early_err", 32'(err_any), 32'd0);
    check("bt_busy_grant", 32'(bif.busGrants), 32'h1);
    tick();
    check("bt_abort_err", 32'(bif.busErrorOut), 32'd1);
    check("bt_abort_fend", 32'(bif.endTransactionOut), 32'd0);
    check("bt_abort_grant", 32'(bif.busGrants), 32'h1);
    tick();
    check("bt_fend_err", 32'(bif.busErrorOut), 32'd0);
    check("bt_fend_fend", 32'(bif.endTransactionOut), 32'd1);
    check("bt_fend_grant", 32'(bif.busGrants), 32'h1);
    tick();
    check("bt_release_grant", 32'(bif.busGrants), 32'd0);
    check("bt_release_fend", 32'(bif.endTransactionOut), 32'd0);
    tick();
    check("bt_idle", 32'(bif.busIdle), 32'd1);

    // End exactly on the timeout cycle wins: no error
    bif.busRequests = 4'b0001; exp_q.push_back(4'b0001);
    wait_grant(n);
    bif.busRequests = 4'b0000;
    bif.beginTransactionIn = 1'b1;
    tick();
    bif.beginTransactionIn = 1'b0;
    repeat (BT) tick();
    bif.endTransactionIn = 1'b1;
    tick();
    bif.endTransactionIn = 1'b0;
    check("bte_release_grant", 32'(bif.busGrants), 32'd0);
    check("bte_no_err", 32'(bif.busErrorOut), 32'd0);
    tick();
    check("bte_no_late_err", 32'(bif.busErrorOut), 32'd0);
    check("bte_no_fend", 32'(bif.endTransactionOut), 32'd0);
    check("bte_idle", 32'(bif.busIdle), 32'd1);

    // Asynchronous reset in the middle of BUSY
    bif.busRequests = 4'b0010; exp_q.push_back(4'b0010);
    wait_grant(n);
    bif.busRequests = 4'b0000;
    bif.beginTransactionIn = 1'b1;
    tick();
    bif.beginTransactionIn = 1'b0;
    repeat (3) tick();
    #2 reset = 1'b0;
    #1;
    check("ar_grant", 32'(bif.busGrants), 32'd0);
    check("ar_err", 32'(bif.busErrorOut), 32'd0);
    check("ar_fend", 32'(bif.endTransactionOut), 32'd0);
    check("ar_idle", 32'(bif.busIdle), 32'd1);
    #2 reset = 1'b1;
    tick();
    bif.busRequests = 4'b1001; exp_q.push_back(4'b0001);
    wait_grant(n);
    check("ar_first_after_reset", 32'(bif.activeMaster), 32'd0);
    bif.busRequests = 4'b0000;
    do_txn(1);
    tick();

    // Three masters: wrap-around from lastGrant = 2, then rotation to 2
    bif3.busRequests = 3'b101;
    tick();
    check("n3_grant_wrap", 32'(bif3.busGrants), 32'h1);
    check("n3_active_wrap", 32'(bif3.activeMaster), 32'd0);
    bif3.beginTransactionIn = 1'b1;
    tick();
    bif3.beginTransactionIn = 1'b0;
    bif3.endTransactionIn = 1'b1;
    tick();
    bif3.endTransactionIn = 1'b0;
    check("n3_release", 32'(bif3.busGrants), 32'd0);
    tick();
    tick();
    check("n3_grant_next", 32'(bif3.busGrants), 32'h4);
    check("n3_active_next", 32'(bif3.activeMaster), 32'd2);
    bif3.busRequests = 3'b000;

    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
